// File: rtl/axis_audio_pkg.sv
// Shared types and helpers for the multi-channel audio packetizer.
package axis_audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PAD     = 3'd4
  } state_e;

  localparam int unsigned HDR_MAGIC_W  = 16;
  localparam int unsigned HDR_SEQ_W    = 16;
  localparam int unsigned HDR_CH_W     = 8;
  localparam int unsigned HDR_RSVD_W   = 8;
  localparam int unsigned HDR_FRAMES_W = 16;

  localparam logic [HDR_MAGIC_W-1:0] DEFAULT_MAGIC = 16'hA5D0;

  // raw carries the sample in its low `width` bits; upper bits are ignored.
  function automatic logic [31:0] sext_sample(input logic [31:0] raw, input int unsigned width);
    logic signed [31:0] t;
    t = signed'(raw << (32 - width));
    return unsigned'(t >>> (32 - width));
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream output register; payload is held stable while stalled.
module axis_reg_slice #(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    s_ready = !valid_q || m_ready;
    data_d  = data_q;
    valid_d = valid_q;
    if (s_ready) begin
      valid_d = s_valid;
      if (s_valid) data_d = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;

endmodule

// File: rtl/axis_audio_packetizer_mc.sv
// Packs an interleaved, frame-marked audio stream into fixed-length packets
// with a 2-word header; misaligned packets are zero-padded and flagged.
module axis_audio_packetizer_mc
  import axis_audio_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned MAX_FRAMES = 64,
  parameter int unsigned SEQ_W      = 16,
  parameter logic [15:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cfg_enable,
  input  logic [15:0]         cfg_frames,
  input  logic [SAMPLE_W-1:0] s_axis_tdata,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [31:0]         stat_pkt_cnt,
  output logic [15:0]         stat_err_cnt
);

  localparam int unsigned LMAX = MAX_FRAMES * CHANNELS;
  localparam int unsigned WC_W = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [15:0]       frames_q, frames_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [WC_W-1:0]   last_wc_q, last_wc_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              err_q, err_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic [15:0] f_clamp;
  logic [15:0] seq16;
  logic [31:0] raw32;
  logic [31:0] sample_ext;
  logic        ch_zero;
  logic        misalign;
  logic        is_last;
  logic        pkt_done;

  logic        sl_valid;
  logic        sl_ready;
  logic [31:0] sl_data;
  logic        sl_last;
  logic        sl_user;

  always_comb begin
    f_clamp = cfg_frames;
    if (cfg_frames == 16'd0) begin
      f_clamp = 16'd1;
    end else if (32'(cfg_frames) > 32'(MAX_FRAMES)) begin
      f_clamp = 16'(MAX_FRAMES);
    end
  end

  always_comb begin
    seq16 = '0;
    seq16[SEQ_W-1:0] = seq_q;
    raw32 = '0;
    raw32[SAMPLE_W-1:0] = s_axis_tdata;
    sample_ext = sext_sample(raw32, SAMPLE_W);
  end

  assign ch_zero  = (ch_q == '0);
  assign misalign = (s_axis_tuser && !ch_zero) || (!s_axis_tuser && ch_zero);
  assign is_last  = (wc_q == last_wc_q);

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    frames_d  = frames_q;
    wc_d      = wc_q;
    last_wc_d = last_wc_q;
    ch_d      = ch_q;
    err_d     = err_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;

    s_axis_tready = 1'b0;
    sl_valid      = 1'b0;
    sl_data       = '0;
    sl_last       = 1'b0;
    sl_user       = 1'b0;
    pkt_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The frame-start sample is left on the bus and consumed later in PAYLOAD.
        s_axis_tready = !(s_axis_tvalid && s_axis_tuser && cfg_enable);
        if (s_axis_tvalid && s_axis_tuser && cfg_enable) begin
          frames_d  = f_clamp;
          last_wc_d = WC_W'(WC_W'(f_clamp) * WC_W'(CHANNELS) - WC_W'(1));
          wc_d      = '0;
          ch_d      = '0;
          err_d     = 1'b0;
          state_d   = ST_HDR0;
        end
      end

      ST_HDR0: begin
        sl_valid = 1'b1;
        sl_data  = {MAGIC, seq16};
        if (sl_ready) state_d = ST_HDR1;
      end

      ST_HDR1: begin
        sl_valid = 1'b1;
        sl_data  = {8'(CHANNELS), 8'h00, frames_q};
        if (sl_ready) state_d = ST_PAYLOAD;
      end

      ST_PAYLOAD: begin
        s_axis_tready = sl_ready;
        if (s_axis_tvalid && sl_ready) begin
          if (misalign) begin
            err_d   = 1'b1;
            state_d = ST_PAD;
          end else begin
            sl_valid = 1'b1;
            sl_data  = sample_ext;
            sl_last  = is_last;
            sl_user  = is_last && err_q;
            ch_d     = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
            wc_d     = wc_q + WC_W'(1);
            pkt_done = is_last;
          end
        end
      end

      ST_PAD: begin
        sl_valid = 1'b1;
        sl_last  = is_last;
        sl_user  = is_last;
        if (sl_ready) begin
          wc_d     = wc_q + WC_W'(1);
          pkt_done = is_last;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (pkt_done) begin
      seq_d     = seq_q + SEQ_W'(1);
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
      err_d     = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      seq_q     <= '0;
      frames_q  <= '0;
      wc_q      <= '0;
      last_wc_q <= '0;
      ch_q      <= '0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      frames_q  <= frames_d;
      wc_q      <= wc_d;
      last_wc_q <= last_wc_d;
      ch_q      <= ch_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  axis_reg_slice #(
    .W(34)
  ) u_out_slice (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .s_data  ({sl_user, sl_last, sl_data}),
    .s_valid (sl_valid),
    .s_ready (sl_ready),
    .m_data  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign stat_pkt_cnt = pkt_cnt_q;
  assign stat_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_axis_audio_packetizer_mc.sv
// Self-checking bench: table of packet cases plus hand sequences, scoreboard on output words.
module tb_axis_audio_packetizer_mc;

  localparam int unsigned CH   = 2;
  localparam int unsigned SW   = 24;
  localparam int unsigned MAXF = 64;
  localparam logic [15:0] MAGIC_TB = 16'hA5D0;
  localparam int unsigned WAIT_MAX = 500;

  logic          ACLK;
  logic          ARESETN;
  logic          cfg_enable;
  logic [15:0]   cfg_frames;
  logic [SW-1:0] s_tdata;
  logic          s_tuser;
  logic          s_tvalid;
  logic          s_tready;
  logic [31:0]   m_tdata;
  logic          m_tuser;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [31:0]   stat_pkt_cnt;
  logic [15:0]   stat_err_cnt;

  axis_audio_packetizer_mc #(
    .CHANNELS   (CH),
    .SAMPLE_W   (SW),
    .MAX_FRAMES (MAXF),
    .SEQ_W      (16),
    .MAGIC      (MAGIC_TB)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .cfg_enable    (cfg_enable),
    .cfg_frames    (cfg_frames),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_err_cnt  (stat_err_cnt)
  );

  typedef struct {
    logic [15:0] frames;
    int unsigned exp_f;
    int unsigned bad_k;
    int unsigned dis_k;
    logic        stall;
    logic        rnd;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned seq_m = 0;
  int unsigned pkt_m = 0;
  int unsigned err_m = 0;
  logic        mon_off = 1'b1;
  logic        toggle_mode = 1'b0;
  logic [33:0] sb[$];
  vec_t        vecs[9];

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      if (toggle_mode) m_tready = ~m_tready;
      else m_tready = 1'b1;
    end
  end

  initial begin
    logic [33:0] w, hw, e;
    logic        hv;
    hv = 1'b0;
    forever begin
      @(negedge ACLK);
      w = {m_tuser, m_tlast, m_tdata};
      if (mon_off || !ARESETN) begin
        hv = 1'b0;
      end else begin
        if (hv && m_tvalid) begin
          total++;
          if (w !== hw) begin
            bad++;
            $display("FAIL stall_stable: got %h expected %h", w, hw);
          end
        end
        hv = m_tvalid && !m_tready;
        hw = w;
        if (m_tvalid && m_tready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word: got %h expected none", w);
          end else begin
            e = sb.pop_front();
            if (w !== e) begin
              bad++;
              $display("FAIL out_word: got %h expected %h", w, e);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_sample(input logic [SW-1:0] d, input logic u);
    int unsigned n;
    logic        done;
    n = 0;
    done = 1'b0;
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    while (!done) begin
      @(negedge ACLK);
      if (s_tready) begin
        done = 1'b1;
      end else begin
        n++;
        if (n >= WAIT_MAX) begin
          total++;
          bad++;
          $display("FAIL send_timeout: got no ready after %0d cycles expected ready", n);
          done = 1'b1;
        end
      end
    end
    @(posedge ACLK);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    @(negedge ACLK);
    while ((sb.size() != 0 || m_tvalid) && n < 5000) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
    end
  endtask

  task automatic run_packet(input vec_t v);
    int unsigned len;
    logic [SW-1:0] d;
    logic          u;
    logic          hit;
    len = v.exp_f * CH;
    toggle_mode = v.stall;
    cfg_enable  = 1'b1;
    cfg_frames  = v.frames;
    hit = 1'b0;
    sb.push_back({2'b00, MAGIC_TB, 16'(seq_m)});
    sb.push_back({2'b00, 8'(CH), 8'h00, 16'(v.exp_f)});
    for (int unsigned k = 1; k <= len && !hit; k++) begin
      d = v.rnd ? SW'($urandom) : SW'(k);
      u = (((k - 1) % CH) == 0);
      if (k == v.bad_k) begin
        send_sample(d, ~u);
        for (int unsigned z = k; z <= len; z++) sb.push_back({(z == len), (z == len), 32'h0});
        hit = 1'b1;
      end else begin
        sb.push_back({1'b0, (k == len), {{(32-SW){d[SW-1]}}, d}});
        send_sample(d, u);
        // Header must keep the frame count latched at packet start.
        if (k == 1) cfg_frames = v.frames ^ 16'h0005;
        if (k == v.dis_k) cfg_enable = 1'b0;
      end
    end
    seq_m++;
    pkt_m++;
    if (hit) err_m++;
    drain();
    toggle_mode = 1'b0;
    check("stat_pkt_cnt", stat_pkt_cnt, 32'(pkt_m));
    check("stat_err_cnt", {16'h0, stat_err_cnt}, 32'(err_m));
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{16'd4,    4,  0, 0, 1'b0, 1'b0};
    vecs[1] = '{16'd4,    4,  0, 0, 1'b1, 1'b0};
    vecs[2] = '{16'd4,    4,  0, 0, 1'b1, 1'b0};
    vecs[3] = '{16'd4,    4,  0, 0, 1'b1, 1'b0};
    vecs[4] = '{16'd4,    4,  4, 0, 1'b0, 1'b0};
    vecs[5] = '{16'd0,    1,  0, 0, 1'b0, 1'b1};
    vecs[6] = '{16'd1000, 64, 0, 0, 1'b0, 1'b1};
    vecs[7] = '{16'd3,    3,  3, 0, 1'b1, 1'b1};
    vecs[8] = '{16'd2,    2,  0, 2, 1'b0, 1'b1};

    ARESETN    = 1'b0;
    cfg_enable = 1'b0;
    cfg_frames = 16'd0;
    s_tdata    = '0;
    s_tuser    = 1'b0;
    s_tvalid   = 1'b0;

    @(negedge ACLK);
    @(negedge ACLK);
    check("rst_tvalid", {31'h0, m_tvalid}, 32'h0);
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_tlast", {31'h0, m_tlast}, 32'h0);
    check("rst_tuser", {31'h0, m_tuser}, 32'h0);
    check("rst_pkt_cnt", stat_pkt_cnt, 32'h0);
    check("rst_err_cnt", {16'h0, stat_err_cnt}, 32'h0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    mon_off = 1'b0;

    for (int unsigned i = 0; i < 9; i++) begin
      if (i > 0 && vecs[i-1].bad_k != 0) send_sample(24'h123456, 1'b0);
      run_packet(vecs[i]);
    end

    // Enable is now low after the mid-packet deassertion: everything is dropped.
    for (int unsigned i = 0; i < 10; i++) send_sample(SW'(i + 100), (i % 2) == 0);
    repeat (5) @(negedge ACLK);
    check("disabled_tvalid", {31'h0, m_tvalid}, 32'h0);
    check("disabled_pkt_cnt", stat_pkt_cnt, 32'(pkt_m));

    cfg_enable = 1'b1;
    cfg_frames = 16'd4;
    mon_off = 1'b1;
    send_sample(24'd11, 1'b1);
    send_sample(24'd12, 1'b0);
    send_sample(24'd13, 1'b1);
    @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    check("mid_rst_tvalid", {31'h0, m_tvalid}, 32'h0);
    check("mid_rst_tdata", m_tdata, 32'h0);
    check("mid_rst_tlast", {31'h0, m_tlast}, 32'h0);
    check("mid_rst_tuser", {31'h0, m_tuser}, 32'h0);
    check("mid_rst_pkt_cnt", stat_pkt_cnt, 32'h0);
    check("mid_rst_err_cnt", {16'h0, stat_err_cnt}, 32'h0);
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    sb.delete();
    seq_m = 0;
    pkt_m = 0;
    err_m = 0;
    mon_off = 1'b0;

    send_sample(24'h0000AA, 1'b0);
    repeat (3) @(negedge ACLK);
    check("post_rst_idle_tvalid", {31'h0, m_tvalid}, 32'h0);
    rv = '{16'd2, 2, 0, 0, 1'b0, 1'b1};
    run_packet(rv);

    check("scoreboard_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
